alu_seq_muldiv: RTL and testbench
=================================

Name: alu_seq_muldiv

Overview:
- Parametrised, handshaked successor to the single-cycle integer ALU.
- Adds XOR, unsigned compare, shifts, an iterative shift-add multiplier and a restoring divider.
- Result and zero flag are registered. Sits between decode/operand-mux and writeback.
- A stall-capable core uses the valid/ready handshake to wait on long ops.

Parameters:
- WIDTH, 32, operand/result width; power of two, >= 8.
- SHW, $clog2(WIDTH), shift-amount width (derived, not overridden).

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  synchronous active-low reset.
- in_valid  input  1  operands/op presented.
- in_ready  output  1  block can accept an op.
- ALUControl  input  4  operation select.
- srcA  input  WIDTH  operand A.
- srcB  input  WIDTH  operand B.
- out_valid  output  1  ALUResult/zero valid.
- out_ready  input  1  consumer accepts result.
- ALUResult  output  WIDTH  registered result.
- zero  output  1  registered (ALUResult == 0).
- busy  output  1  high in BUSY state.

Behaviour:
- Decided interface: one clock; reset synchronous, active-low; clock clk, reset rst_n.
- Ops (ALUControl):
  - 0000 add; 0001 sub; 0010 and; 0011 or; 0100 slt (signed); 0101 sltu; 0110 xor.
  - 0111 sll; 1000 srl; 1001 sra; shift amount = srcB[SHW-1:0].
  - 1010 mul (low WIDTH bits of product); 1011 mulhu (high WIDTH bits, unsigned).
  - 1100 divu; 1101 remu.
  - 1110/1111: result 0, single-cycle class.
- Arithmetic is modulo 2^WIDTH, no overflow flag. slt/sltu produce 0 or 1, zero-extended.
- FSM states: IDLE, BUSY, DONE.
  - in_ready = (state==IDLE); out_valid = (state==DONE); busy = (state==BUSY).
  - IDLE, accept (in_valid && in_ready), single-cycle op: register result and zero, go to DONE. out_valid is high the cycle after acceptance.
  - IDLE, accept, op 1010-1101: latch operands and op, clear accumulator, load iteration counter with WIDTH, go to BUSY.
  - BUSY: one iteration per cycle, counter decrements. On the last iteration (counter==1), register result and zero, go to DONE. out_valid first high exactly WIDTH+1 cycles after the acceptance edge.
  - DONE: hold ALUResult/zero stable while out_valid && !out_ready. On out_ready go to IDLE; the next accept can occur in the following cycle.
  - in_valid is ignored outside IDLE. Operand changes after acceptance have no effect.
- Multiplier: 2*WIDTH-bit product register, radix-2 shift-add, LSB-first over the multiplier.
- Divider: restoring, MSB-first, WIDTH-bit remainder with one extra bit for the trial subtract.
- Divide by zero:
  - divu returns all ones; remu returns srcA.
  - Still takes the full WIDTH+1 latency, no exception.
- zero is computed from the final registered result for every op, including mul/div.
- Reset (rst_n==0 at a clock edge, any state including mid-BUSY): state->IDLE, ALUResult=0, zero=0, out_valid=0, busy=0, counter=0. Any in-flight op is discarded.
- in_ready is 1 from the first edge after reset deasserts.

Test Plan:
- WIDTH=32; add, A=0x7FFFFFFF, B=1 -> out_valid next cycle, ALUResult=0x80000000, zero=0. Then sub, A=5, B=5 -> 0, zero=1.
- slt A=0xFFFFFFFF, B=1 -> 1; sltu same operands -> 0. sra A=0x80000000, B=0x21 (shamt 1) -> 0xC0000000. srl same -> 0x40000000.
- mul A=0xFFFFFFFF, B=0xFFFFFFFF -> busy for 32 cycles, out_valid at cycle 33, ALUResult=0x00000001. mulhu same operands -> 0xFFFFFFFE.
- divu A=100, B=7 -> 14; remu -> 2. divu A=123, B=0 -> 0xFFFFFFFF; remu A=123, B=0 -> 123. All at latency 33.
- Backpressure: hold out_ready=0 for 5 cycles after out_valid -> result, zero and out_valid stable, in_ready=0, new in_valid ignored. Release -> IDLE next cycle, next op accepted.
- Pull rst_n low at BUSY cycle 10 of a divu -> next edge IDLE, out_valid=0, ALUResult=0. A following add 2+3 returns 5 with no residue from the aborted op.

Source files
------------

// File: rtl/alu_seq_muldiv.sv
// alu_seq_muldiv: handshaked integer ALU with iterative multiply and divide.
// Single-cycle ops (add/sub/logic/compare/shift) complete one cycle after
// acceptance; mul/mulhu/divu/remu iterate one bit per cycle for WIDTH cycles.
// Ports:
//   clk, rst_n            clock (rising edge), synchronous active-low reset
//   in_valid / in_ready   operand handshake (ready only in IDLE)
//   ALUControl[3:0]       operation select
//   srcA, srcB            operands, sampled at acceptance only
//   out_valid / out_ready result handshake (valid only in DONE)
//   ALUResult, zero       registered result and (result == 0)
//   busy                  iterative op in progress
module alu_seq_muldiv #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       ALUControl,
  input  logic [WIDTH-1:0] srcA,
  input  logic [WIDTH-1:0] srcB,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] ALUResult,
  output logic             zero,
  output logic             busy
);

  localparam int unsigned SHW = $clog2(WIDTH);
  localparam int unsigned CW  = SHW + 1;
  localparam int unsigned PW  = 2 * WIDTH;

  localparam logic [3:0] OP_ADD  = 4'b0000;
  localparam logic [3:0] OP_SUB  = 4'b0001;
  localparam logic [3:0] OP_AND  = 4'b0010;
  localparam logic [3:0] OP_OR   = 4'b0011;
  localparam logic [3:0] OP_SLT  = 4'b0100;
  localparam logic [3:0] OP_SLTU = 4'b0101;
  localparam logic [3:0] OP_XOR  = 4'b0110;
  localparam logic [3:0] OP_SLL  = 4'b0111;
  localparam logic [3:0] OP_SRL  = 4'b1000;
  localparam logic [3:0] OP_SRA  = 4'b1001;
  localparam logic [3:0] OP_MUL  = 4'b1010;
  localparam logic [3:0] OP_REMU = 4'b1101;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   result_q, result_d;
  logic               zero_q, zero_d;
  logic [3:0]         op_q, op_d;
  logic [WIDTH-1:0]   opnd_q, opnd_d;   // multiplicand (mul) or divisor (div)
  logic [PW-1:0]      prod_q, prod_d;   // {acc/remainder, multiplier/quotient}
  logic [CW-1:0]      cnt_q, cnt_d;

  logic [SHW-1:0]     shamt;
  logic [WIDTH-1:0]   alu_c;
  logic               long_op_c;
  logic               accept_c;

  logic [WIDTH:0]     mul_sum;
  logic [PW-1:0]      mul_next;
  logic [WIDTH:0]     div_shift;
  logic [WIDTH-1:0]   div_diff;
  logic               div_ge;
  logic [PW-1:0]      div_next;
  logic [PW-1:0]      step_next;
  logic [WIDTH-1:0]   step_result;

  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = (state_q == S_DONE);
  assign busy      = (state_q == S_BUSY);
  assign ALUResult = result_q;
  assign zero      = zero_q;

  assign shamt     = srcB[SHW-1:0];
  assign long_op_c = (ALUControl >= OP_MUL) && (ALUControl <= OP_REMU);
  assign accept_c  = in_valid && in_ready;

  // Single-cycle result; codes 1110/1111 (and the long ops) yield 0 here.
  always_comb begin
    alu_c = '0;
    unique case (ALUControl)
      OP_ADD:  alu_c = srcA + srcB;
      OP_SUB:  alu_c = srcA - srcB;
      OP_AND:  alu_c = srcA & srcB;
      OP_OR:   alu_c = srcA | srcB;
      OP_SLT:  alu_c = WIDTH'($signed(srcA) < $signed(srcB));
      OP_SLTU: alu_c = WIDTH'(srcA < srcB);
      OP_XOR:  alu_c = srcA ^ srcB;
      OP_SLL:  alu_c = srcA << shamt;
      OP_SRL:  alu_c = srcA >> shamt;
      OP_SRA:  alu_c = WIDTH'($signed(srcA) >>> shamt);
      default: alu_c = '0;
    endcase
  end

  // One iteration of the shift-add multiplier and the restoring divider.
  // The divider keeps remainder < divisor, so a WIDTH-bit difference is exact;
  // with a zero divisor every trial succeeds, giving all-ones and rem = dividend.
  always_comb begin
    mul_sum   = {1'b0, prod_q[PW-1:WIDTH]} + (prod_q[0] ? {1'b0, opnd_q} : '0);
    mul_next  = {mul_sum, prod_q[WIDTH-1:1]};
    div_shift = {prod_q[PW-1:WIDTH], prod_q[WIDTH-1]};
    div_diff  = div_shift[WIDTH-1:0] - opnd_q;
    div_ge    = (div_shift >= {1'b0, opnd_q});
    div_next  = div_ge ? {div_diff, prod_q[WIDTH-2:0], 1'b1}
                       : {div_shift[WIDTH-1:0], prod_q[WIDTH-2:0], 1'b0};
    step_next = op_q[2] ? div_next : mul_next;
    // op bit 0 selects the high half: mulhu product-high, remu remainder.
    step_result = op_q[0] ? step_next[PW-1:WIDTH] : step_next[WIDTH-1:0];
  end

  // Next-state and datapath control.
  always_comb begin
    state_d  = state_q;
    result_d = result_q;
    zero_d   = zero_q;
    op_d     = op_q;
    opnd_d   = opnd_q;
    prod_d   = prod_q;
    cnt_d    = cnt_q;

    unique case (state_q)
      S_IDLE: begin
        if (accept_c) begin
          if (long_op_c) begin
            op_d    = ALUControl;
            opnd_d  = ALUControl[2] ? srcB : srcA;
            prod_d  = {{WIDTH{1'b0}}, (ALUControl[2] ? srcA : srcB)};
            cnt_d   = CW'(WIDTH);
            state_d = S_BUSY;
          end else begin
            result_d = alu_c;
            zero_d   = (alu_c == '0);
            state_d  = S_DONE;
          end
        end
      end
      S_BUSY: begin
        prod_d = step_next;
        cnt_d  = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          result_d = step_result;
          zero_d   = (step_result == '0);
          state_d  = S_DONE;
        end
      end
      S_DONE: begin
        if (out_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      result_q <= '0;
      zero_q   <= 1'b0;
      op_q     <= '0;
      opnd_q   <= '0;
      prod_q   <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      result_q <= result_d;
      zero_q   <= zero_d;
      op_q     <= op_d;
      opnd_q   <= opnd_d;
      prod_q   <= prod_d;
      cnt_q    <= cnt_d;
    end
  end

endmodule

// File: tb/tb_alu_seq_muldiv.sv
// Directed bench for alu_seq_muldiv (WIDTH=32) with hand-computed expectations.
module tb_alu_seq_muldiv;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  ALUControl;
  logic [31:0] srcA;
  logic [31:0] srcB;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] ALUResult;
  logic        zero;
  logic        busy;

  int n_checks;
  int n_errors;

  alu_seq_muldiv #(.WIDTH(32)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .ALUControl(ALUControl),
    .srcA      (srcA),
    .srcB      (srcB),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .ALUResult (ALUResult),
    .zero      (zero),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one op, scramble inputs after acceptance, measure latency and busy cycles.
  task automatic run_op(input string tag, input logic [3:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp_res, input logic exp_z,
                        input int exp_lat, input int exp_busy);
    int lat;
    int nbusy;
    check({tag, "_in_ready"}, 32'(in_ready), 32'd1);
    in_valid   = 1'b1;
    ALUControl = op;
    srcA       = a;
    srcB       = b;
    tick();
    in_valid   = 1'b0;
    ALUControl = ~op;
    srcA       = ~a;
    srcB       = ~b;
    lat   = 1;
    nbusy = 0;
    while (!out_valid && lat < 100) begin
      if (busy) nbusy++;
      tick();
      lat++;
    end
    check({tag, "_lat"}, 32'(lat), 32'(exp_lat));
    check({tag, "_busy"}, 32'(nbusy), 32'(exp_busy));
    check({tag, "_res"}, ALUResult, exp_res);
    check({tag, "_zero"}, 32'(zero), 32'(exp_z));
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check({tag, "_idle"}, 32'(out_valid), 32'd0);
  endtask

  initial begin
    logic [31:0] held;
    n_checks   = 0;
    n_errors   = 0;
    rst_n      = 1'b0;
    in_valid   = 1'b0;
    out_ready  = 1'b0;
    ALUControl = 4'h0;
    srcA       = '0;
    srcB       = '0;
    tick();
    tick();
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_result", ALUResult, 32'd0);
    check("rst_zero", 32'(zero), 32'd0);
    rst_n = 1'b1;
    tick();
    check("post_rst_ready", 32'(in_ready), 32'd1);

    // Single-cycle ops
    run_op("add",  4'b0000, 32'h7FFFFFFF, 32'h00000001, 32'h80000000, 1'b0, 1, 0);
    run_op("sub",  4'b0001, 32'd5,        32'd5,        32'h00000000, 1'b1, 1, 0);
    run_op("and",  4'b0010, 32'hF0F0F0F0, 32'h0FF00FF0, 32'h00F000F0, 1'b0, 1, 0);
    run_op("or",   4'b0011, 32'hF0000000, 32'h0000000F, 32'hF000000F, 1'b0, 1, 0);
    run_op("slt",  4'b0100, 32'hFFFFFFFF, 32'h00000001, 32'h00000001, 1'b0, 1, 0);
    run_op("sltu", 4'b0101, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b1, 1, 0);
    run_op("xor",  4'b0110, 32'hAAAA5555, 32'hFFFF0000, 32'h55555555, 1'b0, 1, 0);
    run_op("sll",  4'b0111, 32'h00000001, 32'h0000001F, 32'h80000000, 1'b0, 1, 0);
    run_op("srl",  4'b1000, 32'h80000000, 32'h00000021, 32'h40000000, 1'b0, 1, 0);
    run_op("sra",  4'b1001, 32'h80000000, 32'h00000021, 32'hC0000000, 1'b0, 1, 0);
    run_op("op_e", 4'b1110, 32'd5,        32'd3,        32'h00000000, 1'b1, 1, 0);
    run_op("op_f", 4'b1111, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 1'b1, 1, 0);

    // Iterative ops: WIDTH busy cycles, result in cycle WIDTH+1
    run_op("mul",    4'b1010, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 1'b0, 33, 32);
    run_op("mulhu",  4'b1011, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 1'b0, 33, 32);
    run_op("mul_z",  4'b1010, 32'h00010000, 32'h00010000, 32'h00000000, 1'b1, 33, 32);
    run_op("mulhu1", 4'b1011, 32'h00010000, 32'h00010000, 32'h00000001, 1'b0, 33, 32);
    run_op("divu",   4'b1100, 32'd100,      32'd7,        32'd14,       1'b0, 33, 32);
    run_op("remu",   4'b1101, 32'd100,      32'd7,        32'd2,        1'b0, 33, 32);
    run_op("divu0",  4'b1100, 32'd123,      32'd0,        32'hFFFFFFFF, 1'b0, 33, 32);
    run_op("remu0",  4'b1101, 32'd123,      32'd0,        32'd123,      1'b0, 33, 32);
    run_op("divu_s", 4'b1100, 32'd7,        32'd100,      32'd0,        1'b1, 33, 32);
    run_op("divu_m", 4'b1100, 32'hFFFFFFFF, 32'd1,        32'hFFFFFFFF, 1'b0, 33, 32);

    // Backpressure: result held while out_ready is low, new requests ignored
    in_valid   = 1'b1;
    ALUControl = 4'b0000;
    srcA       = 32'd40;
    srcB       = 32'd2;
    tick();
    ALUControl = 4'b0001;
    srcA       = 32'd9;
    srcB       = 32'd9;
    held       = 32'd42;
    for (int i = 0; i < 5; i++) begin
      check("bp_valid", 32'(out_valid), 32'd1);
      check("bp_result", ALUResult, held);
      check("bp_zero", 32'(zero), 32'd0);
      check("bp_ready", 32'(in_ready), 32'd0);
      tick();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("bp_release_idle", 32'(in_ready), 32'd1);
    check("bp_release_valid", 32'(out_valid), 32'd0);
    run_op("bp_next", 4'b0110, 32'h0000FFFF, 32'h0000FF00, 32'h000000FF, 1'b0, 1, 0);

    // Reset in the middle of a divide, then a clean add
    in_valid   = 1'b1;
    ALUControl = 4'b1100;
    srcA       = 32'd100;
    srcB       = 32'd7;
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 9; i++) tick();
    check("abort_busy_before", 32'(busy), 32'd1);
    rst_n = 1'b0;
    tick();
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_valid", 32'(out_valid), 32'd0);
    check("abort_result", ALUResult, 32'd0);
    check("abort_zero", 32'(zero), 32'd0);
    rst_n = 1'b1;
    tick();
    run_op("abort_add", 4'b0000, 32'd2, 32'd3, 32'd5, 1'b0, 1, 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
